// File: rtl/lut_counter_pkg.sv
// Shared constants for the LUT event counter: default geometry, default truth
// table and the legal WIDTH range.
package lut_counter_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 8;
  localparam logic [(1<<DEF_WIDTH)-1:0] DEF_LUT_INIT = 16'hE6C4;

  function automatic bit width_ok(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a history flop; rise pulses for one clk
// on each 0->1 transition of the asynchronous input.
module edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic a,
  output logic rise
);

  logic [2:0] sync_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_pipe <= '0;
    else          sync_pipe <= {sync_pipe[1:0], a};
  end

  assign rise = sync_pipe[1] & ~sync_pipe[2];

endmodule

// File: rtl/lut_event_counter.sv
// Up/down event counter driven by asynchronous inc/dec strobes; the count
// indexes a writable flop-based truth table whose bit is output as data.
module lut_event_counter
  import lut_counter_pkg::*;
#(
  parameter int                      WIDTH    = DEF_WIDTH,
  parameter logic [(1<<WIDTH)-1:0]   LUT_INIT = DEF_LUT_INIT,
  parameter bit                      SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             lut_we,
  input  logic [WIDTH-1:0] lut_addr,
  input  logic             lut_wdata,
  output logic [WIDTH-1:0] count,
  output logic             data,
  output logic             tc
);

  localparam int              DEPTH = 1 << WIDTH;
  localparam logic [WIDTH-1:0] CMAX = '1;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("lut_event_counter: WIDTH out of range");
  end

  logic             inc_ev, dec_ev;
  logic [WIDTH-1:0] cnt_nxt;
  logic             tc_nxt;
  logic [DEPTH-1:0] lut;

  edge_sync u_inc_sync (.clk(clk), .reset_n(reset_n), .a(inc), .rise(inc_ev));
  edge_sync u_dec_sync (.clk(clk), .reset_n(reset_n), .a(dec), .rise(dec_ev));

  // clr/load win outright; an event landing in the same cycle is simply lost
  always_comb begin
    cnt_nxt = count;
    tc_nxt  = 1'b0;
    if (clr) begin
      cnt_nxt = '0;
    end else if (load) begin
      cnt_nxt = load_value;
    end else if (inc_ev && !dec_ev) begin
      if (count == CMAX) begin
        tc_nxt  = 1'b1;
        cnt_nxt = SATURATE ? CMAX : '0;
      end else begin
        cnt_nxt = count + WIDTH'(1);
      end
    end else if (dec_ev && !inc_ev) begin
      if (count == '0) begin
        tc_nxt  = 1'b1;
        cnt_nxt = SATURATE ? '0 : CMAX;
      end else begin
        cnt_nxt = count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= cnt_nxt;
      tc    <= tc_nxt;
    end
  end

  // data reads the pre-edge table, so a write shows up one edge later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lut  <= LUT_INIT;
      data <= LUT_INIT[0];
    end else begin
      data <= lut[count];
      if (lut_we) lut[lut_addr] <= lut_wdata;
    end
  end

endmodule
